// File: rtl/cla_serial_subtractor_if.sv
// Handshake and operand/result bundle for the nibble-serial CLA subtractor.
// The master issues start with operands; the slave answers with ready/done
// and the registered difference, borrow and signed-overflow flags.
interface cla_serial_subtractor_if #(
    parameter int N = 32
);
    logic         start;
    logic [N-1:0] in1;
    logic [N-1:0] in2;
    logic         ready;
    logic         done;
    logic [N-1:0] diff;
    logic         bout;
    logic         of;

    modport master (
        output start,
        output in1,
        output in2,
        input  ready,
        input  done,
        input  diff,
        input  bout,
        input  of
    );

    modport slave (
        input  start,
        input  in1,
        input  in2,
        output ready,
        output done,
        output diff,
        output bout,
        output of
    );
endinterface

// File: rtl/cla_serial_subtractor.sv
// Nibble-serial two's-complement subtractor. diff = in1 + ~in2 + 1 is formed
// one 4-bit carry-lookahead slice per clock, LSB nibble first, with the carry
// held in a register between steps. Results are registered and held from the
// done pulse until the next accepted start.

// 4-bit carry-lookahead slice: all four internal carries come straight from
// the generate/propagate terms rather than rippling bit to bit.
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bit
            assign p[gi]   = a[gi] ^ b[gi];
            assign g[gi]   = a[gi] & b[gi];
            assign sum[gi] = p[gi] ^ c[gi];
        end
    endgenerate

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign cout = c[4];
endmodule

module cla_serial_subtractor #(
    parameter int N = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    cla_serial_subtractor_if.slave  bus
);
    localparam int M     = N / 4;
    localparam int IDX_W = (M > 1) ? $clog2(M) : 1;

    // Operand width must split into at least two whole nibbles.
    generate
        if ((N % 4) != 0 || N < 8) begin : g_bad_width
            $error("cla_serial_subtractor: N must be a multiple of 4 and >= 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;

    logic [N-1:0]       a_reg;
    logic [N-1:0]       a_next;
    logic [N-1:0]       b_reg;      // holds ~in2 so the slice only ever adds
    logic [N-1:0]       b_next;
    logic [N-1:0]       diff_reg;
    logic [N-1:0]       diff_next;
    logic               carry_reg;
    logic               carry_next;
    logic               bout_reg;
    logic               bout_next;
    logic               of_reg;
    logic               of_next;
    logic [IDX_W-1:0]   idx_reg;
    logic [IDX_W-1:0]   idx_next;

    logic               ready;
    logic               done;
    logic               accept;
    logic               running;
    logic               last_step;

    logic [3:0]         a_nibs [M];
    logic [3:0]         b_nibs [M];
    logic [3:0]         a_nib;
    logic [3:0]         b_nib;
    logic [3:0]         slice_sum;
    logic               slice_cout;
    logic [M-1:0]       nib_wr;

    // Nibble views of the latched operands, selected by the step index.
    genvar gi;
    generate
        for (gi = 0; gi < M; gi++) begin : g_nib
            assign a_nibs[gi] = a_reg[4*gi +: 4];
            assign b_nibs[gi] = b_reg[4*gi +: 4];
            assign nib_wr[gi] = running && (idx_reg == IDX_W'(gi));
            // Each result nibble clears on acceptance, loads on its own step,
            // and otherwise holds.
            assign diff_next[4*gi +: 4] = accept     ? 4'h0 :
                                          nib_wr[gi] ? slice_sum :
                                                       diff_reg[4*gi +: 4];
        end
    endgenerate

    assign a_nib = a_nibs[idx_reg];
    assign b_nib = b_nibs[idx_reg];

    // The single lookahead slice shared by every step.
    cla4_slice u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_reg),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    assign running   = (state_reg == RUN);
    assign last_step = running && (idx_reg == IDX_W'(M - 1));
    assign accept    = bus.start && ready;

    // Next state and handshake outputs; DONE accepts a new start just like IDLE.
    always_comb begin
        state_next = state_reg;
        ready      = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                ready = 1'b1;
                if (bus.start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (idx_reg == IDX_W'(M - 1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                ready = 1'b1;
                done  = 1'b1;
                state_next = bus.start ? RUN : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath next values: latch operands on accept, step one nibble in RUN.
    always_comb begin
        a_next     = a_reg;
        b_next     = b_reg;
        carry_next = carry_reg;
        idx_next   = idx_reg;
        bout_next  = bout_reg;
        of_next    = of_reg;
        if (accept) begin
            a_next     = bus.in1;
            b_next     = ~bus.in2;
            carry_next = 1'b1;
            idx_next   = '0;
            bout_next  = 1'b0;
            of_next    = 1'b0;
        end else if (running) begin
            carry_next = slice_cout;
            idx_next   = idx_reg + IDX_W'(1);
            if (last_step) begin
                idx_next  = '0;
                bout_next = ~slice_cout;
                // Operand signs differ (in2 sign is the inverse of b_reg MSB)
                // and the result sign departs from the minuend sign.
                of_next   = (a_reg[N-1] != ~b_reg[N-1]) &&
                            (slice_sum[3] != a_reg[N-1]);
            end
        end
    end

    // State register; reset returns to IDLE without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Operand, carry, index and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            idx_reg   <= '0;
            diff_reg  <= '0;
            bout_reg  <= 1'b0;
            of_reg    <= 1'b0;
        end else begin
            a_reg     <= a_next;
            b_reg     <= b_next;
            carry_reg <= carry_next;
            idx_reg   <= idx_next;
            diff_reg  <= diff_next;
            bout_reg  <= bout_next;
            of_reg    <= of_next;
        end
    end

    assign bus.ready = ready;
    assign bus.done  = done;
    assign bus.diff  = diff_reg;
    assign bus.bout  = bout_reg;
    assign bus.of    = of_reg;
endmodule
